load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Memory-access initiator between the execute stage and the byte-wide data memory (8-bit per address).
//  Sequences LB/LH/LW/LBU/LHU and SB/SH/SW as 1/2/4 single-byte transfers, little-endian.
//  Assembles and extends load data, and stalls the pipeline while busy.
// PARAMETERS
//  A_WIDTH  20  data-memory address width; mem_addr = low A_WIDTH bits of the byte address
// PORTS
//  clk        in   1        clock
//  rst        in   1        asynchronous, active-high reset
//  req_valid  in   1        execute stage presents an access
//  req_ready  out  1        LSU accepts; high only in IDLE
//  is_store   in   1        1 = store, 0 = load
//  funct3     in   3        RV32I load/store funct3
//  addr       in   32       byte address (ALU result)
//  wdata      in   32       store data (rs2)
//  resp_valid out  1        one-cycle pulse: access complete
//  rdata      out  32       extended load data; valid with resp_valid; 0 for stores
//  err        out  1        valid with resp_valid; illegal funct3 (or misaligned, see CONFIGURATION)
//  stall      out  1        ~req_ready & ~resp_valid: hold the pipeline
//  mem_addr   out  A_WIDTH  byte address to data memory
//  mem_wdata  out  8        byte to write
//  mem_we     out  1        byte write enable; memory writes on posedge clk
//  mem_rdata  in   8        combinational read byte at mem_addr
// BEHAVIOUR
//  Reset values: state=IDLE, req_ready=1, resp_valid=0, rdata=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//  IDLE: on req_valid & req_ready, latch addr/wdata/funct3/is_store and set cnt=0.
//    N = 1 (funct3[1:0]=00), 2 (01), 4 (10).
//    Illegal: load funct3 in {3,6,7}; store funct3 other than {0,1,2}.
//    Illegal requests go straight to RESP with err=1 and perform no memory access.
//  ACCESS: byte cnt in progress, cnt = 0..N-1.
//    mem_addr = (addr + cnt) mod 2^A_WIDTH; wraps at the top of memory.
//    Store: mem_we=1, mem_wdata = wdata[8*cnt +: 8].
//    Load: mem_we=0; mem_rdata captured into buf[8*cnt +: 8] at the clock edge.
//    After cnt=N-1, go to RESP.
//  RESP: resp_valid=1 for exactly one cycle, then IDLE.
//    rdata per funct3: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW = buf.
//  Latency: accept edge at cycle 0; resp_valid in cycle N+1; next accept possible in cycle N+2.
//  mem_we is 0 in every state except ACCESS for stores.
//  req_valid is ignored while not IDLE; inputs need not be held after acceptance.
//  Reset mid-ACCESS: immediate return to IDLE with mem_we=0. Bytes already written stay written; no response is issued.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, go IDLE->RESP with err=1 and no memory access.
//  MISALIGN_TRAP_EN undefined:
//    Misaligned accesses complete normally byte by byte; err flags illegal funct3 only.
// STRUCTURE
//  lsu_pkg: funct3 localparams (F3_B/H/W/BU/HU), state enum lsu_state_t, function access_bytes(funct3) -> 1/2/4.
//  Sub-module load_extend: combinational buf[31:0] + funct3 -> rdata; the FSM and byte counter stay in the top level.
// TESTING
//  1. Memory 0x100..0x103 = 78,56,34,12; LW 0x100 -> resp_valid in cycle 5, rdata=0x12345678, err=0, stall high in cycles 1-4.
//  2. Byte at 0x20 = 0x80: LB -> 0xFFFFFF80; LBU -> 0x00000080.
//     Bytes 0x30..0x31 = 01,80: LH -> 0xFFFF8001; LHU -> 0x00008001.
//  3. SH wdata=0xCAFEBEEF at 0x10 -> mem[0x10]=EF, mem[0x11]=BE, mem[0x12] unchanged; mem_we high exactly 2 cycles.
//  4. LW 0x103, bytes 0x103..0x106 = 11,22,33,44:
//     macro defined -> resp in cycle 1 with err=1 and mem_we never asserted;
//     macro undefined -> rdata=0x44332211, err=0.
//  5. SW 0xAABBCCDD at 0x40; assert rst after 2 bytes -> mem[0x40]=DD, mem[0x41]=CC, 0x42/0x43 unchanged;
//     resp_valid never pulses; req_ready=1 after reset.
//  6. LW at 2^A_WIDTH-2 -> mem_addr sequence 0xFFFFE, 0xFFFFF, 0x00000, 0x00001 (unaligned: macro undefined);
//     load with funct3=3 -> err=1, no memory access.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and helpers that classify a request from its funct3 and address.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_illegal(input logic is_store, input logic [2:0] funct3);
        if (is_store)
            return !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        return (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: picks the loaded bytes out of the assembly
// buffer and sign- or zero-extends them according to funct3.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] load_buf,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
    always_comb begin
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{24{load_buf[7]}}, load_buf[7:0]};
            F3_H:    rdata = {{16{load_buf[15]}}, load_buf[15:0]};
            F3_W:    rdata = load_buf;
            F3_BU:   rdata = {24'd0, load_buf[7:0]};
            F3_HU:   rdata = {16'd0, load_buf[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: serialises RV32I loads and stores into little-endian byte
// transfers on an 8-bit data memory. Define MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int A_WIDTH = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               is_store,
    input  logic [2:0]         funct3,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic               resp_valid,
    output logic [31:0]        rdata,
    output logic               err,
    output logic               stall,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               mem_we,
    input  logic [7:0]         mem_rdata
);

    lsu_state_t         state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [A_WIDTH-1:0] addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        buf_q;
    logic [2:0]         funct3_q;
    logic               is_store_q;
    logic               err_q;

    logic               req_err;
    logic               last_byte;
    logic               in_access;
    logic [31:0]        ext_data;

    // Address bits above the memory window are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:A_WIDTH];

`ifdef MISALIGN_TRAP_EN
    assign req_err = is_illegal(is_store, funct3) | is_misaligned(funct3, addr[1:0]);
`else
    assign req_err = is_illegal(is_store, funct3);
`endif

    assign last_byte = ({1'b0, cnt_q} == access_bytes(funct3_q) - 3'd1);
    assign in_access = (state_q == ST_ACCESS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_d   = 2'd0;
                    state_d = req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (last_byte) state_d = ST_RESP;
                else           cnt_d   = cnt_q + 2'd1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            funct3_q   <= '0;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && req_valid) begin
                addr_q     <= addr[A_WIDTH-1:0];
                wdata_q    <= wdata;
                funct3_q   <= funct3;
                is_store_q <= is_store;
                err_q      <= req_err;
                buf_q      <= '0;
            end else if (in_access && !is_store_q) begin
                buf_q[8*cnt_q +: 8] <= mem_rdata;
            end
        end
    end

    load_extend u_load_extend (
        .load_buf (buf_q),
        .funct3   (funct3_q),
        .rdata    (ext_data)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign stall      = ~req_ready & ~resp_valid;
    assign err        = resp_valid & err_q;
    assign rdata      = (resp_valid && !is_store_q && !err_q) ? ext_data : '0;

    // Memory outputs are held at zero outside ACCESS so the bus is quiet when idle.
    assign mem_addr   = in_access ? addr_q + A_WIDTH'(cnt_q) : '0;
    assign mem_we     = in_access & is_store_q;
    assign mem_wdata  = mem_we ? wdata_q[8*cnt_q +: 8] : 8'd0;

endmodule
